stack_echo_checker: RTL and testbench
=====================================

STACK_ECHO_CHECKER -- requirements
Module: stack_echo_checker

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, UART payload width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 64, bytes per test burst (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle clocks between received bytes.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that launches a test; ignored unless idle.
REQ-007 SHALL have port seed  input  PAYLOAD_BITS  pattern base, sampled on accepted start.
REQ-008 SHALL have ports uart_tx_en output 1, uart_tx_busy input 1, uart_tx_data output PAYLOAD_BITS, driving an external uart_tx.
REQ-009 SHALL have ports uart_rx_valid input 1, uart_rx_data input PAYLOAD_BITS, uart_rx_break input 1, from an external uart_rx.
REQ-010 SHALL have outputs busy 1, done 1, pass 1, timeout 1, err_count 8, first_err_idx 8 (test status).

Function
REQ-011 SHALL implement FSM IDLE -> SEND -> RECV -> DONE; start in IDLE or DONE -> SEND next cycle; all counters and flags cleared on entry to SEND.
REQ-012 SHALL, in SEND, transmit bytes i=1..STACK_DEPTH with uart_tx_data = (seed + i) mod 2^PAYLOAD_BITS, stable while uart_tx_en high.
REQ-013 SHALL pulse uart_tx_en for exactly one cycle only when uart_tx_busy is low, then hold it low at least one cycle before the next pulse.
REQ-014 SHALL move SEND -> RECV on the cycle after the STACK_DEPTH-th tx_en pulse.
REQ-015 SHALL, in RECV, compare the k-th received byte (k=0..STACK_DEPTH-1) against (seed + STACK_DEPTH - k) mod 2^PAYLOAD_BITS, i.e. reversed send order.
REQ-016 SHALL increment err_count (saturating at 255) on each mismatch, on each uart_rx_break pulse, and on each uart_rx_valid during SEND.
REQ-017 SHALL latch first_err_idx = k of the first mismatching byte (255 for a break or SEND-phase byte) and never overwrite it within a test.
REQ-018 SHALL move RECV -> DONE on the cycle after the STACK_DEPTH-th uart_rx_valid.
REQ-019 SHALL, in DONE, hold done=1 and pass=1 iff err_count==0 and timeout==0; rx_valid in DONE is ignored.
REQ-020 SHALL drive busy=1 in SEND and RECV, else 0.
REQ-021 SHALL ignore start while busy; simultaneous start and rx_valid in DONE restarts and discards the byte.

Reset
REQ-022 SHALL asynchronously force on resetn low: state IDLE, uart_tx_en=0, uart_tx_data=0, busy=0, done=0, pass=0, timeout=0, err_count=0, first_err_idx=0, all internal counters 0.
REQ-023 SHALL, on reset assertion mid-SEND or mid-RECV, abandon the test with no tx_en pulse issued after reset release until a new start.

Configuration
REQ-024 SHALL, with macro STACK_ECHO_CHECKER_TIMEOUT_EN defined, count clocks in RECV since the last uart_rx_valid (or RECV entry) and, reaching TIMEOUT_CYCLES, set timeout=1 and move to DONE with pass=0.
REQ-025 SHALL, without STACK_ECHO_CHECKER_TIMEOUT_EN, omit the timeout counter, hold timeout=0, and wait in RECV indefinitely.

Verification
REQ-026 SHALL verify: seed=0x30, STACK_DEPTH=64, model echoes 0x70..0x31 -> 64 tx bytes 0x31..0x70, done=1, pass=1, err_count=0.
REQ-027 SHALL verify: same as REQ-026 but 10th received byte (k=9) corrupted to 0x00 -> pass=0, err_count=1, first_err_idx=9.
REQ-028 SHALL verify: seed=0xF0, STACK_DEPTH=64 -> tx bytes wrap 0xF1..0xFF,0x00..0x30; correct reversed echo -> pass=1.
REQ-029 SHALL verify: uart_tx_busy held high 500 cycles after first pulse -> no further tx_en until busy low; one pulse per byte, 64 total.
REQ-030 SHALL verify: with STACK_ECHO_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=100, model echoes 10 bytes then stops -> timeout=1, done=1, pass=0 exactly 100 cycles after 10th rx_valid.
REQ-031 SHALL verify: resetn pulsed low after 20 tx bytes -> all outputs 0 immediately, FSM idle, no tx_en until next start.

Source files
------------

// File: rtl/stack_echo_checker.sv
// stack_echo_checker: sends a seed-based byte burst to a UART and checks that it comes back reversed.
// Ports: clk/resetn; start+seed launch; uart_tx_* out; uart_rx_* in; busy/done/pass/timeout/err_count/first_err_idx. Option: STACK_ECHO_CHECKER_TIMEOUT_EN.
module stack_echo_checker #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int STACK_DEPTH    = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [PAYLOAD_BITS-1:0] seed,
  output logic                    uart_tx_en,
  input  logic                    uart_tx_busy,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
  input  logic                    uart_rx_break,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [7:0]              err_count,
  output logic [7:0]              first_err_idx
);

  localparam int PW = PAYLOAD_BITS;
  localparam logic [7:0] DEPTH = 8'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RECV,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] seed_q, seed_d;
  logic [PW-1:0] tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_cnt_q, tx_cnt_d;
  logic [7:0]    rx_cnt_q, rx_cnt_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    first_q, first_d;
  logic          timeout_q, timeout_d;

  logic          act;
  logic [PW-1:0] exp_byte;
  logic          mis;
  logic          ev_brk;
  logic          ev_early;
  logic [1:0]    n_err;
  logic [8:0]    err_sum;
  logic          tmo_hit;

`ifdef STACK_ECHO_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Idle clocks since RECV entry or the last received byte.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (state_q != S_RECV || uart_rx_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    err_d     = err_q;
    first_d   = first_q;
    timeout_d = timeout_q;

    act      = (state_q == S_SEND) || (state_q == S_RECV);
    exp_byte = seed_q + PW'(DEPTH - rx_cnt_q);
    mis      = (state_q == S_RECV) && uart_rx_valid &&
               (uart_rx_data != exp_byte);
    ev_brk   = act && uart_rx_break;
    ev_early = (state_q == S_SEND) && uart_rx_valid;
    n_err    = {1'b0, mis} + {1'b0, ev_brk} + {1'b0, ev_early};
    err_sum  = {1'b0, err_q} + {7'd0, n_err};

    // err_q saturates and never returns to zero, so zero means no error yet.
    if (n_err != 2'd0) begin
      err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
      if (err_q == 8'd0) first_d = mis ? rx_cnt_q : 8'hFF;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SEND;
          seed_d    = seed;
          tx_en_d   = 1'b0;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          err_d     = '0;
          first_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_SEND: begin
        if (tx_en_q) begin
          tx_en_d = 1'b0;
          if (tx_cnt_q == DEPTH) state_d = S_RECV;
        end else if (!uart_tx_busy && tx_cnt_q != DEPTH) begin
          tx_en_d   = 1'b1;
          tx_cnt_d  = tx_cnt_q + 8'd1;
          tx_data_d = seed_q + PW'(tx_cnt_q + 8'd1);
        end
      end
      S_RECV: begin
        if (uart_rx_valid) begin
          rx_cnt_d = rx_cnt_q + 8'd1;
          if (rx_cnt_q == DEPTH - 8'd1) state_d = S_DONE;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      seed_q    <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_q     <= '0;
      first_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_q     <= err_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
    end
  end

  assign uart_tx_en    = tx_en_q;
  assign uart_tx_data  = tx_data_q;
  assign busy          = (state_q == S_SEND) || (state_q == S_RECV);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == 8'd0) && !timeout_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_stack_echo_checker.sv
// tb_stack_echo_checker: table rows, random bursts, reset and timeout checks for stack_echo_checker.
// A UART model captures tx bytes with busy emulation; the echo is a model stack popped in reverse.
module tb_stack_echo_checker;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       uart_tx_busy = 1'b0;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_break = 1'b0;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       busy, done, pass, timeout;
  logic [7:0] err_count, first_err_idx;

  stack_echo_checker #(
    .PAYLOAD_BITS(8),
    .STACK_DEPTH(N),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .seed(seed_in),
    .uart_tx_en(uart_tx_en),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_data(uart_tx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .err_count(err_count),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // UART tx model state
  int         mcnt = 0;
  int         mviol = 0;
  int         mbad = 0;
  logic [7:0] mseed = 8'h00;
  int         busy_first = 2;
  int         busy_max = 3;
  int         busy_left = 0;
  logic       prev_en = 1'b0;

  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx_en) begin
        if (uart_tx_busy || prev_en) mviol++;
        e = mseed + 8'(mcnt + 1);
        if (uart_tx_data != e) mbad++;
        busy_left = (mcnt == 0) ? busy_first : int'($urandom_range(1, busy_max));
        mcnt++;
      end
      prev_en = uart_tx_en;
      uart_tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  logic [7:0] mstack[N];
  logic [7:0] corr[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] s, input bit with_rx);
    mseed = s;
    mcnt = 0;
    mviol = 0;
    mbad = 0;
    for (int i = 0; i < N; i++) begin
      mstack[i] = s + 8'(i + 1);
      corr[i] = 8'h00;
    end
    start = 1'b1;
    seed_in = s;
    if (with_rx) begin
      uart_rx_valid = 1'b1;
      uart_rx_data = 8'h5A;
    end
    tick();
    start = 1'b0;
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int lim, input string nm);
    int c = 0;
    while (mcnt < n && c < lim) begin
      tick();
      c++;
    end
    check(nm, longint'(mcnt >= n), 1);
  endtask

  task automatic wait_done(input int lim, input string nm);
    int c = 0;
    while (!done && c < lim) begin
      tick();
      c++;
    end
    check(nm, longint'(done), 1);
  endtask

  task automatic echo(input int from, input int to, input int gmax);
    for (int k = from; k < to; k++) begin
      repeat ($urandom_range(0, gmax)) tick();
      uart_rx_valid = 1'b1;
      uart_rx_data = mstack[N-1-k] ^ corr[k];
      tick();
      uart_rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_break();
    uart_rx_break = 1'b1;
    tick();
    uart_rx_break = 1'b0;
  endtask

  typedef struct {
    logic [7:0] seed;
    int         busy1;
    int         ck;
    logic [7:0] cval;
    bit         brk;
    bit         early;
    bit         exp_pass;
    int         exp_err;
    int         exp_first;
  } vec_t;

  vec_t vt[7];

  initial begin
    int         ex_err;
    int         ex_first;
    int         c0;
    logic [7:0] s;

    vt[0] = '{8'h30, 2, -1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
    vt[1] = '{8'h30, 2, 9, 8'h00, 1'b0, 1'b0, 1'b0, 1, 9};
    vt[2] = '{8'hF0, 2, -1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
    vt[3] = '{8'h30, 500, -1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
    vt[4] = '{8'h55, 3, -1, 8'h00, 1'b1, 1'b0, 1'b0, 1, 255};
    vt[5] = '{8'hAA, 1, -1, 8'h00, 1'b0, 1'b1, 1'b0, 1, 255};
    vt[6] = '{8'h07, 2, 3, 8'h00, 1'b1, 1'b0, 1'b0, 2, 255};

    #1 resetn = 1'b0;
    #2;
    check("reset_outs",
          {busy, done, pass, timeout, err_count, first_err_idx,
           uart_tx_en, uart_tx_data}, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    for (int r = 0; r < 7; r++) begin
      busy_first = vt[r].busy1;
      busy_max = 3;
      do_start(vt[r].seed, r == 2);
      if (vt[r].ck >= 0) corr[vt[r].ck] = mstack[N-1-vt[r].ck] ^ vt[r].cval;
      check($sformatf("row%0d_busy", r), longint'(busy), 1);
      if (vt[r].early) begin
        wait_tx(5, 200, $sformatf("row%0d_tx5", r));
        uart_rx_valid = 1'b1;
        uart_rx_data = mstack[N-1];
        tick();
        uart_rx_valid = 1'b0;
      end
      if (vt[r].busy1 > 100) begin
        wait_tx(1, 50, $sformatf("row%0d_tx1", r));
        repeat (300) tick();
        check($sformatf("row%0d_hold", r), mcnt, 1);
      end
      wait_tx(N, N * 8 + vt[r].busy1 + 50, $sformatf("row%0d_txall", r));
      tick();
      tick();
      if (vt[r].brk) pulse_break();
      echo(0, N, 2);
      wait_done(50, $sformatf("row%0d_done", r));
      check($sformatf("row%0d_pass", r), longint'(pass), longint'(vt[r].exp_pass));
      check($sformatf("row%0d_err", r), err_count, vt[r].exp_err);
      check($sformatf("row%0d_first", r), first_err_idx, vt[r].exp_first);
      check($sformatf("row%0d_txcnt", r), mcnt, N);
      check($sformatf("row%0d_txdata", r), mbad, 0);
      check($sformatf("row%0d_txproto", r), mviol, 0);
      check($sformatf("row%0d_idle", r), longint'(busy), 0);
    end

    for (int it = 0; it < 6; it++) begin
      s = 8'($urandom);
      busy_first = $urandom_range(1, 4);
      busy_max = $urandom_range(1, 4);
      do_start(s, 1'b0);
      ex_err = 0;
      ex_first = 0;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          corr[k] = 8'($urandom_range(1, 255));
          if (ex_err == 0) ex_first = k;
          ex_err++;
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        wait_tx(3, 100, $sformatf("rnd%0d_tx3", it));
        start = 1'b1;
        seed_in = ~s;
        tick();
        start = 1'b0;
      end
      wait_tx(N, N * 8 + 50, $sformatf("rnd%0d_txall", it));
      tick();
      tick();
      echo(0, N, 2);
      wait_done(50, $sformatf("rnd%0d_done", it));
      check($sformatf("rnd%0d_pass", it), longint'(pass), longint'(ex_err == 0));
      check($sformatf("rnd%0d_err", it), err_count, ex_err);
      check($sformatf("rnd%0d_first", it), first_err_idx, ex_first);
      check($sformatf("rnd%0d_txdata", it), mbad, 0);
      check($sformatf("rnd%0d_txproto", it), mviol, 0);
    end

    busy_first = 2;
    busy_max = 2;
    do_start(8'h40, 1'b0);
    wait_tx(20, 200, "rst_tx20");
    #3 resetn = 1'b0;
    #1;
    check("rst_outs",
          {busy, done, pass, timeout, err_count, first_err_idx,
           uart_tx_en, uart_tx_data}, 0);
    c0 = mcnt;
    tick();
    tick();
    resetn = 1'b1;
    repeat (200) tick();
    check("rst_no_tx", mcnt, c0);
    check("rst_idle", {busy, done}, 0);

    do_start(8'h12, 1'b0);
    wait_tx(N, N * 8 + 50, "tmo_txall");
    tick();
    tick();
    echo(0, 10, 2);
`ifdef STACK_ECHO_CHECKER_TIMEOUT_EN
    begin
      int c = 0;
      bit seen = 1'b0;
      while (!seen && c < 150) begin
        tick();
        c++;
        if (timeout) seen = 1'b1;
      end
      check("tmo_cycles", c, 100);
      check("tmo_done", longint'(done), 1);
      check("tmo_pass", longint'(pass), 0);
      check("tmo_flag", longint'(timeout), 1);
    end
`else
    repeat (150) tick();
    check("notmo_flag", longint'(timeout), 0);
    check("notmo_busy", longint'(busy), 1);
    echo(10, N, 2);
    wait_done(50, "notmo_done");
    check("notmo_pass", longint'(pass), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
